// File: rtl/qbus_dal_sequencer_pkg.sv
// Shared types for the QBUS DAL transceiver sequencer: FSM state encodings,
// owner codes and the DAL data width.
package qbus_dal_sequencer_pkg;

  localparam int DAL_W = 22;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_DRIVE   = 2'd2,
    ST_RELEASE = 2'd3
  } dal_state_e;

  typedef enum logic {
    OWN_SLV = 1'b0,
    OWN_DMA = 1'b1
  } dal_owner_e;

endpackage

// File: rtl/qbus_dal_sequencer.sv
// Owns the shared Am2908 DAL transceiver path and sequences direction
// turnaround between the slave-reply and DMA-master requesters.
module qbus_dal_sequencer
  import qbus_dal_sequencer_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int HOLD   = 1
) (
  input  logic              clk20,
  input  logic              reset_L,
  input  logic              binit,
  input  logic              slv_req,
  input  logic [DAL_W-1:0]  slv_data,
  output logic              slv_gnt,
  input  logic              dma_req,
  input  logic [DAL_W-1:0]  dma_data,
  input  logic              dma_wtbt,
  input  logic              dma_bs7,
  output logic              dma_gnt,
  output logic              on_bus,
  output logic              DALtx,
  output logic              DALst,
  output logic              DALbe_L,
  output logic [DAL_W-1:0]  DALreg,
  output logic              wtbt_o,
  output logic              bs7_o,
  output logic [1:0]        fsm_state
);

  // Handshake: a requester raises its req level and holds it for the whole
  // ownership; its gnt is high from SETUP through DRIVE, and on_bus marks the
  // cycles where BDAL carries its data. Dropping req ends ownership (no preemption).

  localparam logic [2:0] SETTLE_LD = 3'(SETTLE - 1);
  localparam logic [2:0] HOLD_LD   = 3'(HOLD - 1);

  dal_state_e state, state_d;
  dal_owner_e owner, owner_d;
  logic [2:0] cnt, cnt_d;
  logic       owner_req;

  logic             slv_gnt_d, dma_gnt_d, drive_d, tx_d;
  logic [DAL_W-1:0] dal_d;
  logic             wtbt_d, bs7_d;

  assign owner_req = (owner == OWN_SLV) ? slv_req : dma_req;
  assign fsm_state = state;

  always_ff @(posedge clk20 or negedge reset_L) begin
    if (!reset_L) begin
      state <= ST_IDLE;
      owner <= OWN_SLV;
      cnt   <= 3'd0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    owner_d = owner;
    cnt_d   = cnt;
    case (state)
      ST_IDLE: begin
        if (!binit) begin
          if (slv_req) begin
            state_d = ST_SETUP;
            owner_d = OWN_SLV;
            cnt_d   = SETTLE_LD;
          end else if (dma_req) begin
            state_d = ST_SETUP;
            owner_d = OWN_DMA;
            cnt_d   = SETTLE_LD;
          end
        end
      end
      ST_SETUP: begin
        // Abort before DRIVE leaves BDAL undriven; only the HOLD tail remains.
        if (binit || !owner_req) begin
          state_d = ST_RELEASE;
          cnt_d   = HOLD_LD;
        end else if (cnt == 3'd0) begin
          state_d = ST_DRIVE;
        end else begin
          cnt_d = cnt - 3'd1;
        end
      end
      ST_DRIVE: begin
        if (binit || !owner_req) begin
          state_d = ST_RELEASE;
          cnt_d   = HOLD_LD;
        end
      end
      ST_RELEASE: begin
        if (cnt == 3'd0) state_d = ST_IDLE;
        else             cnt_d   = cnt - 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad outputs are registered decodes of the current state, so every
  // response lands one edge after the FSM reaches the corresponding state.
  always_comb begin
    tx_d      = (state != ST_IDLE);
    drive_d   = (state == ST_DRIVE);
    slv_gnt_d = (state == ST_SETUP || state == ST_DRIVE) && (owner == OWN_SLV);
    dma_gnt_d = (state == ST_SETUP || state == ST_DRIVE) && (owner == OWN_DMA);
    dal_d     = DALreg;
    wtbt_d    = wtbt_o;
    bs7_d     = bs7_o;
    if (state == ST_IDLE) begin
      dal_d  = '0;
      wtbt_d = 1'b0;
      bs7_d  = 1'b0;
    end else if (state == ST_SETUP || state == ST_DRIVE) begin
      if (owner == OWN_SLV) begin
        dal_d  = slv_data;
        wtbt_d = 1'b0;
        bs7_d  = 1'b0;
      end else begin
        dal_d  = dma_data;
        wtbt_d = dma_wtbt;
        bs7_d  = dma_bs7;
      end
    end
  end

  always_ff @(posedge clk20 or negedge reset_L) begin
    if (!reset_L) begin
      DALtx   <= 1'b0;
      DALst   <= 1'b0;
      DALbe_L <= 1'b1;
      on_bus  <= 1'b0;
      slv_gnt <= 1'b0;
      dma_gnt <= 1'b0;
      DALreg  <= '0;
      wtbt_o  <= 1'b0;
      bs7_o   <= 1'b0;
    end else begin
      DALtx   <= tx_d;
      DALst   <= drive_d;
      DALbe_L <= !drive_d;
      on_bus  <= drive_d;
      slv_gnt <= slv_gnt_d;
      dma_gnt <= dma_gnt_d;
      DALreg  <= dal_d;
      wtbt_o  <= wtbt_d;
      bs7_o   <= bs7_d;
    end
  end

endmodule

// File: tb/tb_qbus_dal_sequencer.sv
// Bench for qbus_dal_sequencer: table-driven cycle vectors on a SETTLE=1 instance,
// a SETUP abort on a SETTLE=4 instance, binit and async-reset corner cases.
module tb_qbus_dal_sequencer;
  import qbus_dal_sequencer_pkg::*;

  localparam int W  = 30;
  localparam int NV = 26;

  // clock/reset block
  logic clk20 = 1'b0;
  logic reset_L;
  always #25 clk20 = ~clk20;

  logic        binit, slv_req, dma_req, dma_wtbt, dma_bs7;
  logic [21:0] slv_data, dma_data;

  logic        slv_gnt_a, dma_gnt_a, on_bus_a, DALtx_a, DALst_a, DALbe_L_a, wtbt_a, bs7_a;
  logic [21:0] DALreg_a;
  logic [1:0]  fsm_state_a;
  logic        slv_gnt_b, dma_gnt_b, on_bus_b, DALtx_b, DALst_b, DALbe_L_b, wtbt_b, bs7_b;
  logic [21:0] DALreg_b;
  logic [1:0]  fsm_state_b;

  qbus_dal_sequencer #(.SETTLE(1), .HOLD(1)) dut_a (
    .clk20(clk20), .reset_L(reset_L), .binit(binit),
    .slv_req(slv_req), .slv_data(slv_data), .slv_gnt(slv_gnt_a),
    .dma_req(dma_req), .dma_data(dma_data), .dma_wtbt(dma_wtbt), .dma_bs7(dma_bs7),
    .dma_gnt(dma_gnt_a), .on_bus(on_bus_a), .DALtx(DALtx_a), .DALst(DALst_a),
    .DALbe_L(DALbe_L_a), .DALreg(DALreg_a), .wtbt_o(wtbt_a), .bs7_o(bs7_a),
    .fsm_state(fsm_state_a)
  );

  qbus_dal_sequencer #(.SETTLE(4), .HOLD(1)) dut_b (
    .clk20(clk20), .reset_L(reset_L), .binit(binit),
    .slv_req(slv_req), .slv_data(slv_data), .slv_gnt(slv_gnt_b),
    .dma_req(dma_req), .dma_data(dma_data), .dma_wtbt(dma_wtbt), .dma_bs7(dma_bs7),
    .dma_gnt(dma_gnt_b), .on_bus(on_bus_b), .DALtx(DALtx_b), .DALst(DALst_b),
    .DALbe_L(DALbe_L_b), .DALreg(DALreg_b), .wtbt_o(wtbt_b), .bs7_o(bs7_b),
    .fsm_state(fsm_state_b)
  );

  wire [W-1:0] obs_a = {slv_gnt_a, dma_gnt_a, on_bus_a, DALtx_a, DALst_a, DALbe_L_a, wtbt_a, bs7_a, DALreg_a};
  wire [W-1:0] obs_b = {slv_gnt_b, dma_gnt_b, on_bus_b, DALtx_b, DALst_b, DALbe_L_b, wtbt_b, bs7_b, DALreg_b};

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] pk(input logic sg, input logic dg, input logic ob,
                                      input logic tx, input logic st, input logic be,
                                      input logic wt, input logic b7, input logic [21:0] r);
    return {sg, dg, ob, tx, st, be, wt, b7, r};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act);
    logic [W-1:0] ex;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: actual %h, scoreboard empty", name, act);
    end else begin
      ex = exp_q.pop_front();
      if (act === ex) n_pass++;
      else $display("FAIL %s: actual %h required %h", name, act, ex);
    end
  endtask

  task automatic tick();
    @(posedge clk20);
    #1;
  endtask

  // continuous invariants on both instances
  int run_a = 0;
  int run_b = 0;
  always @(negedge clk20) begin
    n_checks++;
    if (!(slv_gnt_a && dma_gnt_a) && (DALbe_L_a || (DALtx_a && run_a >= 1))) n_pass++;
    else $display("FAIL inv_a: gnt=%b%b be_L=%b tx=%b run=%0d", slv_gnt_a, dma_gnt_a, DALbe_L_a, DALtx_a, run_a);
    n_checks++;
    if (!(slv_gnt_b && dma_gnt_b) && (DALbe_L_b || (DALtx_b && run_b >= 4))) n_pass++;
    else $display("FAIL inv_b: gnt=%b%b be_L=%b tx=%b run=%0d", slv_gnt_b, dma_gnt_b, DALbe_L_b, DALtx_b, run_b);
    run_a = DALtx_a ? run_a + 1 : 0;
    run_b = DALtx_b ? run_b + 1 : 0;
  end

  typedef struct packed {
    logic        sr;
    logic        dr;
    logic        bi;
    logic [21:0] sd;
    logic [21:0] dd;
    logic [W-1:0] ex;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mkv(input logic sr, input logic dr, input logic bi,
                               input logic [21:0] sd, input logic [21:0] dd, input logic [W-1:0] ex);
    vec_t v;
    v.sr = sr; v.dr = dr; v.bi = bi; v.sd = sd; v.dd = dd; v.ex = ex;
    return v;
  endfunction

  initial begin
    logic [21:0] s1, s2, s3, d1, d2;
    logic [W-1:0] idl;
    logic [W-1:0] ab[7];
    s1 = 22'o177777; s2 = 22'o001234; s3 = 22'o070707;
    d1 = 22'o017570; d2 = 22'o000123;
    idl = pk(0,0,0,0,0,1,0,0,22'd0);

    // slave only: grant after edge 1, drive after edge 2, release and HOLD tail
    vecs[0]  = mkv(1,0,0,s1,d1, idl);
    vecs[1]  = mkv(1,0,0,s1,d1, pk(1,0,0,1,0,1,0,0,s1));
    vecs[2]  = mkv(1,0,0,s1,d1, pk(1,0,1,1,1,0,0,0,s1));
    vecs[3]  = mkv(0,0,0,s1,d1, pk(1,0,1,1,1,0,0,0,s1));
    vecs[4]  = mkv(0,0,0,s1,d1, pk(0,0,0,1,0,1,0,0,s1));
    vecs[5]  = mkv(0,0,0,s1,d1, idl);
    // both requests: slave first, one IDLE cycle, then DMA; DMA data change in DRIVE
    vecs[6]  = mkv(1,1,0,s2,d1, idl);
    vecs[7]  = mkv(1,1,0,s2,d1, pk(1,0,0,1,0,1,0,0,s2));
    vecs[8]  = mkv(0,1,0,s2,d1, pk(1,0,1,1,1,0,0,0,s2));
    vecs[9]  = mkv(0,1,0,s2,d1, pk(0,0,0,1,0,1,0,0,s2));
    vecs[10] = mkv(0,1,0,s2,d1, idl);
    vecs[11] = mkv(0,1,0,s2,d1, pk(0,1,0,1,0,1,1,1,d1));
    vecs[12] = mkv(0,1,0,s2,d1, pk(0,1,1,1,1,0,1,1,d1));
    vecs[13] = mkv(0,1,0,s2,d2, pk(0,1,1,1,1,0,1,1,d2));
    vecs[14] = mkv(0,0,0,s2,d2, pk(0,1,1,1,1,0,1,1,d2));
    vecs[15] = mkv(0,0,0,s2,d2, pk(0,0,0,1,0,1,1,1,d2));
    vecs[16] = mkv(0,0,0,s2,d2, idl);
    // binit during DRIVE, then held with both requests high
    vecs[17] = mkv(1,0,0,s3,d2, idl);
    vecs[18] = mkv(1,0,0,s3,d2, pk(1,0,0,1,0,1,0,0,s3));
    vecs[19] = mkv(1,0,0,s3,d2, pk(1,0,1,1,1,0,0,0,s3));
    vecs[20] = mkv(1,1,1,s3,d2, pk(1,0,1,1,1,0,0,0,s3));
    vecs[21] = mkv(1,1,1,s3,d2, pk(0,0,0,1,0,1,0,0,s3));
    vecs[22] = mkv(1,1,1,s3,d2, idl);
    vecs[23] = mkv(1,1,1,s3,d2, idl);
    vecs[24] = mkv(1,1,0,s3,d2, idl);
    vecs[25] = mkv(1,1,0,s3,d2, pk(1,0,0,1,0,1,0,0,s3));

    reset_L = 1'b0; binit = 1'b0; slv_req = 1'b0; dma_req = 1'b0;
    dma_wtbt = 1'b1; dma_bs7 = 1'b1; slv_data = '0; dma_data = '0;
    tick(); tick();
    exp_q.push_back(idl);               check("reset_a", obs_a);
    exp_q.push_back(idl);               check("reset_b", obs_b);
    exp_q.push_back(W'(ST_IDLE));       check("reset_state", W'(fsm_state_a));
    reset_L = 1'b1;

    for (int i = 0; i < NV; i++) begin
      slv_req = vecs[i].sr; dma_req = vecs[i].dr; binit = vecs[i].bi;
      slv_data = vecs[i].sd; dma_data = vecs[i].dd;
      exp_q.push_back(vecs[i].ex);
      tick();
      check($sformatf("vec%0d", i), obs_a);
    end

    // settle both instances back to IDLE
    slv_req = 1'b0; dma_req = 1'b0; binit = 1'b0;
    repeat (4) tick();
    exp_q.push_back(W'(ST_IDLE)); check("idle_b", W'(fsm_state_b));

    // SETTLE=4 abort: dma_req dropped before SETUP expires
    ab[0] = idl;
    ab[1] = pk(0,1,0,1,0,1,1,1,d2);
    ab[2] = pk(0,1,0,1,0,1,1,1,d2);
    ab[3] = pk(0,0,0,1,0,1,1,1,d2);
    ab[4] = idl; ab[5] = idl; ab[6] = idl;
    for (int c = 0; c < 7; c++) begin
      dma_req = (c < 2);
      exp_q.push_back(ab[c]);
      tick();
      check($sformatf("abort%0d", c), obs_b);
    end

    // async reset in the middle of a slave DRIVE
    slv_req = 1'b1; slv_data = s1;
    repeat (3) tick();
    exp_q.push_back(pk(1,0,1,1,1,0,0,0,s1)); check("pre_reset_drive", obs_a);
    #10;
    reset_L = 1'b0;
    #1;
    exp_q.push_back(idl);           check("async_reset_a", obs_a);
    exp_q.push_back(idl);           check("async_reset_b", obs_b);
    exp_q.push_back(W'(ST_IDLE));   check("async_reset_state", W'(fsm_state_a));
    slv_req = 1'b0;
    tick();
    reset_L = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
